ground_scroll_sequencer: RTL
============================

// Module: ground_scroll_sequencer
// PURPOSE
//  Game-flow controller that sequences the scrolling ground renderer: owns game state, ground scroll offset and speed.
//  Turns the per-frame refresh strobe into a synchronous tick and advances ground_position by speed per frame, modulo PERIOD.
//  Ramps speed over time, freezes scrolling on collision and restarts on the start button.
//  Sits between the VGA/frame timing and the ground pixel generator; drives its game_status, ground_position and speed.
// PARAMETERS
//  PERIOD       40   ground pattern tile width in pixels; position wraps modulo PERIOD
//  POS_W        6    ground_position width; must satisfy 2**POS_W >= PERIOD
//  SPD_W        4    speed width
//  MAX_SPEED    8    speed saturation value; must be < PERIOD
//  RAMP_FRAMES  600  frames between speed increments
//  CRASH_FRAMES 30   frames spent in CRASH before OVER
//  SCORE_W      16   score width
// PORTS
//  clkdiv           in   32       clock-divider bus; block clocks on posedge clkdiv[0]; other bits unused
//  N_rst            in   1        asynchronous, active-low reset
//  fresh            in   1        frame refresh strobe; a falling edge marks frame end
//  start            in   1        start/restart button, level
//  collide          in   1        collision flag from the sprite logic, level
//  game_status      out  1        1 only in RUN
//  game_over        out  1        1 only in OVER
//  ground_position  out  POS_W    scroll offset, 0..PERIOD-1
//  speed            out  SPD_W    pixels per frame, 1..MAX_SPEED
//  score            out  SCORE_W  frames survived, binary or BCD (see CONFIGURATION)
//  frame_tick       out  1        one-cycle pulse per detected frame end
// BEHAVIOUR
//  - Reset (N_rst=0, async): state=IDLE; ground_position=0; speed=1; score=0; frame_tick=0; game_status=0; game_over=0.
//    Ramp/crash counters=0; synchronizers cleared.
//  - fresh: 2-flop synchronizer, then falling-edge detect -> frame_tick.
//    frame_tick rises on the 3rd clkdiv[0] edge after fresh falls.
//  - start: 2-flop synchronizer plus rising-edge detect (start_evt). A held button never retriggers.
//  - collide: sampled only on frame_tick and only in RUN. Ignored in every other state.
//  - FSM states: IDLE, RUN, CRASH, OVER.
//    IDLE:  outputs hold reset values; start_evt -> RUN.
//    RUN:   on each frame_tick:
//           - collide=1 -> CRASH. Position, speed and score are not updated on that tick; collide takes priority over advance.
//           - else: ground_position <= (ground_position+speed) wraps modulo PERIOD (sum on POS_W+1 bits, single conditional subtract of PERIOD); score <= score+1, saturating at all-ones; ramp_cnt++.
//           - ramp_cnt==RAMP_FRAMES-1 -> ramp_cnt=0 and speed <= min(speed+1, MAX_SPEED).
//    CRASH: position, speed and score frozen; crash_cnt++ per tick; crash_cnt==CRASH_FRAMES-1 on a tick -> OVER, crash_cnt=0.
//    OVER:  outputs frozen, game_over=1; start_evt -> RUN.
//           In that same cycle: ground_position=0, speed=1, score=0, ramp_cnt=0.
//  - start_evt in RUN or CRASH: ignored.
//  - start_evt and frame_tick in the same cycle in IDLE/OVER: the state changes to RUN; the tick is not applied.
//    The first advance happens on the next tick.
//  - Registered outputs only; game_status and game_over are decoded from the state register.
// CONFIGURATION
//  SCORE_BCD_EN defined: score is SCORE_W/4 packed BCD digits, incremented with per-digit carry.
//    Saturates at all 9s.
//  SCORE_BCD_EN undefined: score is plain binary, saturating at 2**SCORE_W-1.
// STRUCTURE
//  Package ground_seq_pkg: state enum (IDLE=0, RUN=1, CRASH=2, OVER=3), default PERIOD/MAX_SPEED constants.
//  Sub-module sync_edge_det: 2-flop synchronizer with rise/fall pulse outputs; instanced for fresh and for start.
//  Everything else stays in the top: FSM, position/speed/score datapath, ramp and crash counters.
// TESTING (bench params: PERIOD=40, MAX_SPEED=3, RAMP_FRAMES=4, CRASH_FRAMES=2)
//  1. Reset value check:
//     N_rst low mid-RUN with position=17 -> immediately (no clock edge) position=0, speed=1, game_status=0, score=0.
//  2. Start and first tick:
//     Pulse start, then one fresh fall -> game_status=1; frame_tick 3 clocks after the fall; position=1; score=1.
//  3. Speed ramp:
//     8 ticks in RUN -> speed 1->2 after tick 4, 2->3 after tick 8.
//     A further 4 ticks -> speed stays 3 (saturated).
//  4. Wrap-around:
//     position=38, speed=3, tick -> position=1.
//     position=37, speed=3 -> position=0.
//  5. Collision and crash sequence:
//     collide=1 on a tick with position=10 -> CRASH, position stays 10.
//     2 more ticks -> game_over=1.
//     start held high across the whole crash -> no restart; a fresh press -> RUN, position=0, speed=1, score=0.
//  6. BCD score (SCORE_BCD_EN):
//     score=0x0099, tick -> 0x0100.
//     Binary build: score=0xFFFF, tick -> stays 0xFFFF.

Source files
------------

// File: rtl/ground_scroll_sequencer_pkg.sv
// ground_seq_pkg: shared types and defaults for the ground scroll sequencer.
// Exports: state_e (IDLE/RUN/CRASH/OVER) and default tile-width and max-speed constants.
// Imported by the top; the sub-module has no package dependency.
package ground_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int DEF_PERIOD    = 40;
  localparam int DEF_MAX_SPEED = 8;

endpackage

// File: rtl/ground_scroll_sequencer_if.sv
// ground_scroll_sequencer_if: game-control bundle between frame timing/sprite logic and the sequencer.
// Inputs to the sequencer: fresh (frame strobe), start (button), collide (sprite hit).
// Outputs: game_status, game_over, ground_position, speed, score, frame_tick.
interface ground_scroll_sequencer_if #(
  parameter int POS_W   = 6,
  parameter int SPD_W   = 4,
  parameter int SCORE_W = 16
);
  logic               fresh;
  logic               start;
  logic               collide;
  logic               game_status;
  logic               game_over;
  logic [POS_W-1:0]   ground_position;
  logic [SPD_W-1:0]   speed;
  logic [SCORE_W-1:0] score;
  logic               frame_tick;

  // master: the environment (frame timing, button, sprite logic)
  modport master (
    output fresh, start, collide,
    input  game_status, game_over, ground_position, speed, score, frame_tick
  );

  // slave: the sequencer itself
  modport slave (
    input  fresh, start, collide,
    output game_status, game_over, ground_position, speed, score, frame_tick
  );
endinterface

// File: rtl/ground_scroll_sequencer_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer for an asynchronous level, with rise/fall pulses.
// Ports: clk_i, rst_ni (async active-low), d_i async level in, rise_o/fall_o one-cycle pulses.
// A pulse is visible after the 2nd clock edge following the input change.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
  logic [2:0] sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= 3'b000;
    else         sh_q <= {sh_q[1:0], d_i};
  end

  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ground_scroll_sequencer.sv
// ground_scroll_sequencer: game-flow FSM owning ground scroll offset, speed and score.
// Ports: clkdiv (bit 0 is the clock, rest unused), N_rst async active-low, bus (slave side of
// ground_scroll_sequencer_if). Optional macro SCORE_BCD_EN selects a packed-BCD score.
module ground_scroll_sequencer
  import ground_seq_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int POS_W        = 6,
  parameter int SPD_W        = 4,
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int RAMP_FRAMES  = 600,
  parameter int CRASH_FRAMES = 30,
  parameter int SCORE_W      = 16
) (
  input  logic [31:0]               clkdiv,
  input  logic                      N_rst,
  ground_scroll_sequencer_if.slave  bus
);
  localparam int RAMP_W  = $clog2(RAMP_FRAMES + 1);
  localparam int CRASH_W = $clog2(CRASH_FRAMES + 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_FRAMES - 1);
  localparam logic [POS_W:0]     PERIOD_X   = (POS_W + 1)'(PERIOD);
  localparam logic [SPD_W-1:0]   SPD_MAX    = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0]   SPD_ONE    = SPD_W'(1);

  logic clk;
  logic clkdiv_unused;
  assign clk           = clkdiv[0];
  assign clkdiv_unused = ^clkdiv[31:1];

  logic frame_evt, start_evt, fresh_rise_unused, start_fall_unused;

  sync_edge_det u_fresh_sync (
    .clk_i (clk), .rst_ni (N_rst), .d_i (bus.fresh),
    .rise_o(fresh_rise_unused), .fall_o(frame_evt)
  );

  sync_edge_det u_start_sync (
    .clk_i (clk), .rst_ni (N_rst), .d_i (bus.start),
    .rise_o(start_evt), .fall_o(start_fall_unused)
  );

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d, pos_adv;
  logic [SPD_W-1:0]   spd_q, spd_d, spd_inc;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic [RAMP_W-1:0]  ramp_q, ramp_d;
  logic [CRASH_W-1:0] crash_q, crash_d;
  logic               tick_q;
  logic [POS_W:0]     pos_sum;

  // Speed never exceeds PERIOD-1, so one conditional subtract is a full modulo.
  assign pos_sum = {1'b0, pos_q} + (POS_W + 1)'(spd_q);
  assign pos_adv = (pos_sum >= PERIOD_X) ? POS_W'(pos_sum - PERIOD_X) : pos_sum[POS_W-1:0];
  assign spd_inc = (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + SPD_ONE;

`ifdef SCORE_BCD_EN
  logic bcd_carry, bcd_all9;
  // Ripple +1 through the digits; an all-9s score holds rather than rolling to zero.
  always_comb begin
    score_inc = score_q;
    bcd_carry = 1'b1;
    bcd_all9  = 1'b1;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      if (score_q[4*i +: 4] != 4'd9) bcd_all9 = 1'b0;
      if (bcd_carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          bcd_carry           = 1'b0;
        end
      end
    end
    if (bcd_all9) score_inc = score_q;
  end
`else
  assign score_inc = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
`endif

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      spd_q   <= SPD_ONE;
      score_q <= '0;
      ramp_q  <= '0;
      crash_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      spd_q   <= spd_d;
      score_q <= score_d;
      ramp_q  <= ramp_d;
      crash_q <= crash_d;
      tick_q  <= frame_evt;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    spd_d   = spd_q;
    score_d = score_q;
    ramp_d  = ramp_q;
    crash_d = crash_q;
    case (state_q)
      // A frame end coinciding with the restart is dropped: the first advance
      // waits for the next frame.
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          state_d = ST_RUN;
          pos_d   = '0;
          spd_d   = SPD_ONE;
          score_d = '0;
          ramp_d  = '0;
          crash_d = '0;
        end
      end
      ST_RUN: begin
        if (frame_evt) begin
          if (bus.collide) begin
            // Freeze on the colliding frame: nothing advances.
            state_d = ST_CRASH;
            crash_d = '0;
          end else begin
            pos_d   = pos_adv;
            score_d = score_inc;
            if (ramp_q == RAMP_LAST) begin
              ramp_d = '0;
              spd_d  = spd_inc;
            end else begin
              ramp_d = ramp_q + RAMP_W'(1);
            end
          end
        end
      end
      ST_CRASH: begin
        if (frame_evt) begin
          if (crash_q == CRASH_LAST) begin
            state_d = ST_OVER;
            crash_d = '0;
          end else begin
            crash_d = crash_q + CRASH_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.game_status     = (state_q == ST_RUN);
  assign bus.game_over       = (state_q == ST_OVER);
  assign bus.ground_position = pos_q;
  assign bus.speed           = spd_q;
  assign bus.score           = score_q;
  assign bus.frame_tick      = tick_q;
endmodule
